// File: rtl/conv3x3_engine_if.sv
// Purpose: window input, kernel write port and filtered pixel output of the 3x3 convolution engine.
// Latency: wiring only; no storage.
// Backpressure: none; the producer offers one window per cycle and the engine always accepts it.
interface conv3x3_engine_if;
    logic [23:0] row0;
    logic [23:0] row1;
    logic [23:0] row2;
    logic        in_valid;
    logic        frame_clr;
    logic        kern_we;
    logic [3:0]  kern_addr;
    logic [7:0]  kern_data;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_eol;
    logic        pix_eof;

    modport master (
        output row0, row1, row2, in_valid, frame_clr, kern_we, kern_addr, kern_data,
        input  pix_out, pix_valid, pix_eol, pix_eof
    );

    modport slave (
        input  row0, row1, row2, in_valid, frame_clr, kern_we, kern_addr, kern_data,
        output pix_out, pix_valid, pix_eol, pix_eof
    );
endinterface

// File: rtl/conv3x3_engine.sv
// Purpose: 3x3 signed-kernel convolution with shift/clamp; window row/column position is tagged at input.
// Latency: 3 cycles from in_valid to pix_valid, one window per cycle.
// Backpressure: none; every accepted window produces exactly one output.
module conv3x3_engine #(
    parameter int SHIFT    = 4,
    parameter int COLS_OUT = 6,
    parameter int ROWS_OUT = 6
) (
    input  logic              clk,
    input  logic              rst,
    conv3x3_engine_if.slave   bus
);
    localparam int CW = (COLS_OUT > 1) ? $clog2(COLS_OUT) : 1;
    localparam int RW = (ROWS_OUT > 1) ? $clog2(ROWS_OUT) : 1;

    // Position flags that travel down the pipeline alongside each window.
    typedef struct packed {
        logic eol;
        logic eof;
    } meta_t;

    logic signed [7:0]  coef [9];
    logic [7:0]         pix  [9];
    logic [23:0]        rows [3];

    logic [CW-1:0]      col, base_col, nxt_col;
    logic [RW-1:0]      row, base_row, nxt_row;
    meta_t              in_meta;

    logic               s1_vld;
    meta_t              s1_meta;
    logic signed [16:0] s1_prod [9];

    logic               s2_vld;
    meta_t              s2_meta;
    logic signed [20:0] s2_sum;

    logic signed [20:0] sum_nxt;
    logic signed [20:0] shr;
    logic [7:0]         clamped;

    assign rows[0] = bus.row0;
    assign rows[1] = bus.row1;
    assign rows[2] = bus.row2;

    // Pixel k = 3*r + c; column 0 is the left pixel in the top byte of each slice.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign pix[3*r+c] = rows[r][23-8*c -: 8];
        end
    end

    // Tag the incoming window with eol/eof; frame_clr makes this window col 0, row 0.
    always_comb begin
        base_col    = bus.frame_clr ? '0 : col;
        base_row    = bus.frame_clr ? '0 : row;
        in_meta.eol = (base_col == CW'(COLS_OUT - 1));
        in_meta.eof = in_meta.eol && (base_row == RW'(ROWS_OUT - 1));
        nxt_col     = in_meta.eol ? '0 : base_col + CW'(1);
        nxt_row     = in_meta.eof ? '0 : (in_meta.eol ? base_row + RW'(1) : base_row);
    end

    // Position counters: advance per accepted window, or clear on a bare frame_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_valid) begin
            col <= nxt_col;
            row <= nxt_row;
        end else if (bus.frame_clr) begin
            col <= '0;
            row <= '0;
        end
    end

    // Kernel store; stage 1 reads the registered value, so a write lands for the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                coef[k] <= '0;
            end
            coef[4] <= 8'(1 << SHIFT);
        end else if (bus.kern_we && (bus.kern_addr <= 4'd8)) begin
            coef[bus.kern_addr] <= bus.kern_data;
        end
    end

    // Stage 1: nine unsigned-pixel by signed-coefficient products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_meta <= '0;
            for (int k = 0; k < 9; k++) begin
                s1_prod[k] <= '0;
            end
        end else begin
            s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                s1_meta <= in_meta;
                for (int k = 0; k < 9; k++) begin
                    s1_prod[k] <= 17'($signed({1'b0, pix[k]})) * 17'(coef[k]);
                end
            end
        end
    end

    // Adder tree input: sign-extend each product to the 21-bit accumulator width.
    always_comb begin
        sum_nxt = '0;
        for (int k = 0; k < 9; k++) begin
            sum_nxt = sum_nxt + {{4{s1_prod[k][16]}}, s1_prod[k]};
        end
    end

    // Stage 2: register the window sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_meta <= '0;
            s2_sum  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_meta <= s1_meta;
                s2_sum  <= sum_nxt;
            end
        end
    end

    // Arithmetic shift then saturate to the unsigned 8-bit pixel range.
    always_comb begin
        shr = s2_sum >>> SHIFT;
        if (shr < 21'sd0) begin
            clamped = 8'd0;
        end else if (shr > 21'sd255) begin
            clamped = 8'd255;
        end else begin
            clamped = shr[7:0];
        end
    end

    // Stage 3: output register; pixel holds while idle, flags only ride with a valid pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pix_out   <= 8'd0;
            bus.pix_valid <= 1'b0;
            bus.pix_eol   <= 1'b0;
            bus.pix_eof   <= 1'b0;
        end else begin
            bus.pix_valid <= s2_vld;
            bus.pix_eol   <= s2_vld && s2_meta.eol;
            bus.pix_eof   <= s2_vld && s2_meta.eof;
            if (s2_vld) begin
                bus.pix_out <= clamped;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Purpose: scoreboard bench for conv3x3_engine; expected pixels and flags are queued at drive time.
// Latency: checks every output lands exactly 3 cycles after its window.
// Backpressure: none exercised; stimulus is back-to-back or with random gaps.
module tb_conv3x3_engine;
    localparam int SHIFT = 4;
    localparam int COLS  = 6;
    localparam int ROWS  = 6;

    typedef struct {
        logic [7:0] pix;
        bit         eol;
        bit         eof;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t              sb[$];
    logic signed [7:0] coef_m [9];
    int                col_m;
    int                row_m;
    logic [7:0]        last_pix;

    conv3x3_engine_if bus();

    conv3x3_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_pix(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        logic [23:0] r [3];
        int acc;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc += int'(r[i][23-8*j -: 8]) * int'(coef_m[3*i+j]);
            end
        end
        acc = acc >>> SHIFT;
        if (acc < 0) return 8'd0;
        if (acc > 255) return 8'd255;
        return acc[7:0];
    endfunction

    // One cycle of stimulus: optional window, optional frame_clr, optional kernel write.
    task automatic send(input bit v, input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                        input bit fc = 1'b0, input bit we = 1'b0,
                        input logic [3:0] wa = 4'd0, input logic [7:0] wd = 8'd0);
        exp_t e;
        int   bc;
        int   br;
        if (v) begin
            bc    = fc ? 0 : col_m;
            br    = fc ? 0 : row_m;
            e.eol = (bc == COLS - 1);
            e.eof = e.eol && (br == ROWS - 1);
            e.pix = model_pix(a, b, c);
            e.cyc = cyc + 3;
            sb.push_back(e);
            col_m = e.eol ? 0 : bc + 1;
            row_m = e.eof ? 0 : (e.eol ? br + 1 : br);
        end else if (fc) begin
            col_m = 0;
            row_m = 0;
        end
        if (we && wa <= 4'd8) coef_m[wa] = wd;
        bus.row0      = a;
        bus.row1      = b;
        bus.row2      = c;
        bus.in_valid  = v;
        bus.frame_clr = fc;
        bus.kern_we   = we;
        bus.kern_addr = wa;
        bus.kern_data = wd;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.frame_clr = 1'b0;
        bus.kern_we   = 1'b0;
    endtask

    task automatic fill_kernel(input logic [7:0] v);
        for (int k = 0; k < 9; k++) send(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 4'(k), v);
    endtask

    task automatic identity_kernel();
        fill_kernel(8'h00);
        send(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 4'd4, 8'(1 << SHIFT));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.frame_clr = 1'b0;
        bus.kern_we   = 1'b0;
        sb.delete();
        for (int k = 0; k < 9; k++) coef_m[k] = 8'sd0;
        coef_m[4] = 8'(1 << SHIFT);
        col_m = 0;
        row_m = 0;
        idle(2);
        check("rst_vld", bus.pix_valid, 0);
        check("rst_pix", bus.pix_out, 0);
        check("rst_flags", {bus.pix_eol, bus.pix_eof}, 0);
        rst = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on each valid pixel, checks hold/flag rules when idle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_pix = 8'h00;
        end else if (bus.pix_valid) begin
            if (sb.size() == 0) begin
                check("unexp_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pix", bus.pix_out, e.pix);
                check("eol", bus.pix_eol, e.eol);
                check("eof", bus.pix_eof, e.eof);
                check("latency", cyc, e.cyc);
            end
            last_pix = bus.pix_out;
        end else begin
            check("idle_flags", {bus.pix_eol, bus.pix_eof}, 0);
            check("hold", bus.pix_out, last_pix);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        bus.row0      = '0;
        bus.row1      = '0;
        bus.row2      = '0;
        bus.in_valid  = 1'b0;
        bus.frame_clr = 1'b0;
        bus.kern_we   = 1'b0;
        bus.kern_addr = '0;
        bus.kern_data = '0;
        do_reset();

        // Identity kernel from reset: centre pixel passes through.
        send(1'b1, 24'($urandom), 24'h108040, 24'($urandom));
        drain();

        // Box sum, back-to-back windows; an out-of-range address write must be ignored.
        fill_kernel(8'h01);
        send(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 4'd12, 8'h55);
        repeat (4) send(1'b1, 24'h101010, 24'h101010, 24'h101010);
        drain();

        // Clamp low and high.
        fill_kernel(8'hFF);
        send(1'b1, 24'h0A0A0A, 24'h0A0A0A, 24'h0A0A0A);
        fill_kernel(8'h7F);
        send(1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        drain();

        // Framing with a random kernel: a full frame plus one, then a frame with gaps.
        for (int k = 0; k < 9; k++) send(1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b1, 4'(k), 8'($urandom_range(0, 255)));
        send(1'b0, 24'h0, 24'h0, 24'h0, 1'b1);
        repeat (37) send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom));
        send(1'b0, 24'h0, 24'h0, 24'h0, 1'b1);
        repeat (36) begin
            send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom));
            idle($urandom_range(0, 2));
        end
        // frame_clr together with a window mid-row restarts the row at that window.
        repeat (3) send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom));
        send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom), 1'b1);
        repeat (6) send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom));
        drain();

        // Kernel write colliding with a window: old coefficient for that window, new for the next.
        identity_kernel();
        send(1'b1, 24'h0, 24'h00C000, 24'h0, 1'b0, 1'b1, 4'd4, 8'h00);
        send(1'b1, 24'h0, 24'h00C000, 24'h0);
        drain();

        // Reset with two windows in flight: nothing emerges, kernel and counters restart.
        fill_kernel(8'h02);
        idle(4);
        send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom));
        send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom));
        do_reset();
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            nv += int'(bus.pix_valid);
        end
        #1;
        check("rst_drop", nv, 0);
        repeat (6) send(1'b1, 24'($urandom), 24'($urandom), 24'($urandom));
        drain();

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
